// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 2-FF synchroniser, mid-bit sampling,
// LSB-first deserialiser, valid/ready output with parity/frame/overrun flags.
module uart_rx_cfg #(
  parameter int unsigned ClksPerBit   = 868,
  parameter int unsigned DataWidthMax = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [4:0]              cfg_i,
  input  logic                    rx_i,
  output logic [DataWidthMax-1:0] rx_data_o,
  output logic                    rx_valid_o,
  input  logic                    rx_ready_i,
  output logic                    parity_err_o,
  output logic                    frame_err_o,
  output logic                    overrun_o,
  output logic                    busy_o
);

  localparam int unsigned CntW = $clog2(ClksPerBit);
  localparam int unsigned IdxW = 3;
  localparam logic [CntW-1:0] HalfTerm = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CntW-1:0] FullTerm = CntW'(ClksPerBit - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                  state;
  logic                    rx_meta;
  logic                    rx_s;
  logic                    rx_prev;
  logic [CntW-1:0]         cnt;
  logic [IdxW-1:0]         bit_idx;
  logic [IdxW-1:0]         last_data;
  logic [1:0]              stop_last;
  logic                    par_en;
  logic                    par_acc;
  logic                    perr;
  logic                    ferr;
  logic [DataWidthMax-1:0] data_q;

  // Config decode: index of last data bit and last stop bit (stop code 3 clamps to 3 stops)
  logic [IdxW-1:0] cfg_last_data_c;
  logic [1:0]      cfg_stop_last_c;
  assign cfg_last_data_c = IdxW'(cfg_i[4:3]) + IdxW'(4);
  assign cfg_stop_last_c = (cfg_i[2:1] == 2'b11) ? 2'd2 : cfg_i[2:1];

  // Synchroniser and previous-sample register for falling-edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Receive FSM with bit timing, deserialiser and registered output word
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      last_data    <= '0;
      stop_last    <= '0;
      par_en       <= 1'b0;
      par_acc      <= 1'b0;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      data_q       <= '0;
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      // Consumer handshake; a load later in this block takes priority
      if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (rx_prev && !rx_s) begin
            state     <= ST_START;
            busy_o    <= 1'b1;
            cnt       <= '0;
            last_data <= cfg_last_data_c;
            stop_last <= cfg_stop_last_c;
            par_en    <= cfg_i[0];
          end
        end

        ST_START: begin
          if (cnt == HalfTerm) begin
            cnt <= '0;
            if (rx_s) begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end else begin
              state   <= ST_DATA;
              bit_idx <= '0;
              data_q  <= '0;
              par_acc <= 1'b0;
              perr    <= 1'b0;
              ferr    <= 1'b0;
            end
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end

        ST_DATA: begin
          if (cnt == FullTerm) begin
            cnt             <= '0;
            data_q[bit_idx] <= rx_s;
            par_acc         <= par_acc ^ rx_s;
            if (bit_idx == last_data) begin
              bit_idx <= '0;
              state   <= par_en ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + IdxW'(1);
            end
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end

        ST_PARITY: begin
          if (cnt == FullTerm) begin
            cnt     <= '0;
            perr    <= par_acc ^ rx_s;
            bit_idx <= '0;
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end

        ST_STOP: begin
          if (cnt == FullTerm) begin
            cnt <= '0;
            if (bit_idx == IdxW'(stop_last)) begin
              state        <= ST_IDLE;
              busy_o       <= 1'b0;
              rx_data_o    <= data_q;
              parity_err_o <= perr;
              frame_err_o  <= ferr | ~rx_s;
              overrun_o    <= rx_valid_o & ~rx_ready_i;
              rx_valid_o   <= 1'b1;
            end else begin
              ferr    <= ferr | ~rx_s;
              bit_idx <= bit_idx + IdxW'(1);
            end
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end

        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg at 16 clocks per bit.
module tb_uart_rx_cfg;

  localparam int unsigned BitClks = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } word_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [4:0] cfg_i = 5'b0;
  logic       rx_i = 1'b1;
  logic       rx_ready_i = 1'b1;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    fall_cyc = 0;
  int    rise_cyc = -1;
  logic  valid_d = 1'b0;
  word_t exp_q[$];

  uart_rx_cfg #(.ClksPerBit(BitClks), .DataWidthMax(8)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cfg_i        (cfg_i),
    .rx_i         (rx_i),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor: compares each accepted word against the head of the scoreboard
  always @(negedge clk_i) begin
    word_t e;
    if (rst_i) begin
      valid_d = 1'b0;
    end else begin
      if (rx_valid_o && !valid_d) rise_cyc = cyc;
      valid_d = rx_valid_o;
      if (rx_valid_o && rx_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word: got data=%02h perr=%0b ferr=%0b ovr=%0b, none expected",
                   rx_data_o, parity_err_o, frame_err_o, overrun_o);
        end else begin
          e = exp_q.pop_front();
          if (rx_data_o !== e.data || parity_err_o !== e.perr ||
              frame_err_o !== e.ferr || overrun_o !== e.ovr) begin
            failures++;
            $display("FAIL word: got data=%02h perr=%0b ferr=%0b ovr=%0b, expected data=%02h perr=%0b ferr=%0b ovr=%0b",
                     rx_data_o, parity_err_o, frame_err_o, overrun_o, e.data, e.perr, e.ferr, e.ovr);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [7:0] d, input logic pe, input logic fe, input logic ov);
    word_t w;
    w.data = d;
    w.perr = pe;
    w.ferr = fe;
    w.ovr  = ov;
    exp_q.push_back(w);
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (BitClks) tick();
  endtask

  // Full frame: start, data LSB first, optional even parity (optionally flipped), stops, idle gap
  task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen, input bit pflip,
                            input int nstop, input int bad_stop);
    logic p;
    fall_cyc = cyc;
    drive_bit(1'b0);
    p = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      drive_bit(d[i]);
      p = p ^ d[i];
    end
    if (pen) drive_bit(p ^ pflip);
    for (int s = 0; s < nstop; s++) drive_bit((s == bad_stop) ? 1'b0 : 1'b1);
    rx_i = 1'b1;
    repeat (2 * BitClks) tick();
  endtask

  initial begin
    tick();
    tick();
    check("reset_outputs", {23'b0, rx_valid_o, rx_data_o, parity_err_o, frame_err_o, overrun_o, busy_o}, 32'h0);
    rst_i = 1'b0;
    repeat (4) tick();

    // 8N1 0xA5; load 2 sync + 8 half-bit + 9 bit periods + 1 clk after rx_i falls
    cfg_i = 5'b11000;
    expect_word(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1, -1);
    check("latency_8n1", 32'(rise_cyc - fall_cyc), 32'd155);

    // 5E2: good parity, then flipped parity bit
    cfg_i = 5'b00011;
    expect_word(8'h13, 1'b0, 1'b0, 1'b0);
    send_frame(8'h13, 5, 1'b1, 1'b0, 2, -1);
    expect_word(8'h13, 1'b1, 1'b0, 1'b0);
    send_frame(8'h13, 5, 1'b1, 1'b1, 2, -1);

    // 7N3 with second stop low, then a clean frame; both stop codes 2 and 3
    cfg_i = 5'b10100;
    expect_word(8'h2B, 1'b0, 1'b1, 1'b0);
    send_frame(8'h2B, 7, 1'b0, 1'b0, 3, 1);
    expect_word(8'h5A, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 7, 1'b0, 1'b0, 3, -1);
    cfg_i = 5'b10110;
    expect_word(8'h2B, 1'b0, 1'b1, 1'b0);
    send_frame(8'h2B, 7, 1'b0, 1'b0, 3, 1);
    expect_word(8'h5A, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 7, 1'b0, 1'b0, 3, -1);

    // 4-clk low glitch: start check rejects it
    rx_i = 1'b0;
    repeat (4) tick();
    rx_i = 1'b1;
    repeat (2) tick();
    check("glitch_busy_high", 32'(busy_o), 32'd1);
    repeat (6) tick();
    check("glitch_busy_low", 32'(busy_o), 32'd0);
    check("glitch_no_valid", 32'(rx_valid_o), 32'd0);
    repeat (BitClks) tick();

    // Overrun: two words with ready low, then a one-cycle ready pulse
    cfg_i = 5'b11000;
    rx_ready_i = 1'b0;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1, -1);
    expect_word(8'h22, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1, -1);
    rx_ready_i = 1'b1;
    tick();
    rx_ready_i = 1'b0;
    check("valid_drop_after_accept", 32'(rx_valid_o), 32'd0);

    // Reset mid-DATA with a held word pending
    send_frame(8'h7E, 8, 1'b0, 1'b0, 1, -1);
    rx_i = 1'b0;
    repeat (BitClks) tick();
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    check("pre_reset_busy_valid", {30'b0, busy_o, rx_valid_o}, 32'h3);
    rst_i = 1'b1;
    #1;
    check("reset_mid_frame", {23'b0, rx_valid_o, rx_data_o, parity_err_o, frame_err_o, overrun_o, busy_o}, 32'h0);
    rx_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    rx_ready_i = 1'b1;
    repeat (4) tick();
    expect_word(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1, -1);

    repeat (BitClks) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
